adder_16bit_arbiter: RTL
========================

ADDER_16BIT_ARBITER -- requirements
Module: adder_16bit_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits.
REQ-002 Parameter NUM_REQ, default 4, number of requesters (2..8); IDW = $clog2(NUM_REQ).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 req_ready  output  NUM_REQ  per-requester grant/accept.
REQ-007 req_a  input  NUM_REQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH].
REQ-008 req_b  input  NUM_REQ*WIDTH  operand B, same packing.
REQ-009 req_cin  input  NUM_REQ  carry-in; requester i at bit i.
REQ-010 rsp_valid  output  1  result held in output register.
REQ-011 rsp_ready  input  1  consumer accepts result.
REQ-012 rsp_id  output  IDW  index of the requester that owns the result.
REQ-013 rsp_sum  output  WIDTH  sum result.
REQ-014 rsp_cout  output  1  carry out of MSB.
REQ-015 rsp_overflow  output  1  signed two's-complement overflow.

Function
REQ-016 Shared adder, one-entry output register; FSM states EMPTY (no result held) and FULL (result held).
REQ-017 Slot free when FSM is EMPTY, or FULL with rsp_ready=1 in the same cycle (drain and refill permitted; throughput 1 op/cycle).
REQ-018 Slot free: exactly one req_ready bit asserts, for the winning requester among the asserted req_valid bits; otherwise req_ready = 0.
REQ-019 Round-robin: priority starts at (last_grant+1) mod NUM_REQ and ascends with wrap; last_grant updates only on an accepted transfer.
REQ-020 Transfer occurs when req_valid[i] and req_ready[i] are both 1; req_ready is combinational from req_valid and the FSM state, with no dependency on operands.
REQ-021 Latency 1: a transfer in cycle N gives rsp_valid=1 with its result in cycle N+1.
REQ-022 Sum computation: rsp_sum = (a + b + cin) mod 2^WIDTH; rsp_cout = bit WIDTH of the full-width sum.
REQ-023 Overflow condition: rsp_overflow = 1 iff a[MSB]==b[MSB] and rsp_sum[MSB]!=a[MSB].
REQ-024 Result hold: while rsp_valid=1 and rsp_ready=0, rsp_id, rsp_sum, rsp_cout and rsp_overflow stay stable, and no new transfer occurs.
REQ-025 FSM transitions: EMPTY->FULL on transfer; FULL->EMPTY on rsp_ready with no transfer; FULL->FULL on rsp_ready with transfer, or on stall.
REQ-026 Starvation bound: a requester holding req_valid is granted within NUM_REQ accepted transfers.
REQ-027 Ignored inputs: req_valid for an index >= NUM_REQ does not exist; operands of non-granted requesters are ignored.

Reset
REQ-028 rst=0 asynchronously forces FSM=EMPTY, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_overflow=0, and last_grant=NUM_REQ-1 (requester 0 highest priority).
REQ-029 A result held at reset is discarded without a handshake; req_ready=0 while rst=0.
REQ-030 Reset release: the block may accept requests in the first rising edge after rst deasserts.

Configuration
REQ-031 Macro ADDER_16BIT_ARB_STATS_EN, when defined, adds output stat_acc_count[15:0] (accepted transfers) and output stat_stall_count[15:0] (cycles with rsp_valid=1 and rsp_ready=0).
REQ-032 Stats counter behaviour: both counters saturate at 0xFFFF and reset to 0.
REQ-033 Stats omitted: without the macro, both ports and their logic are absent; all other behaviour is identical.

Verification
REQ-034 Single request: req_valid=0001, a=0x0001, b=0x0002, cin=1 -> next cycle rsp_valid=1, id=0, sum=0x0004, cout=0, ovf=0.
REQ-035 Overflow and carry: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0.
REQ-036 Fairness: req_valid=1111 held, rsp_ready=1 after reset -> grants in order 0,1,2,3,0 on consecutive cycles, one rsp per cycle.
REQ-037 Backpressure: rsp_ready=0 for 3 cycles with a result held -> outputs stable, req_ready=0, stat_stall_count+=3 (if STATS_EN); when rsp_ready=1, a pending request is accepted in the same cycle.
REQ-038 Reset mid-operation: assert rst with rsp_valid=1 -> rsp_valid falls immediately; after release with req_valid=1010, requester 1 is granted first.

Source files
------------

// File: rtl/adder_16bit_arbiter.sv
// adder_16bit_arbiter: round-robin arbitrated shared adder with a one-entry output register.
// Optional stat counters are enabled by defining ADDER_16BIT_ARB_STATS_EN.
module adder_16bit_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic                     rsp_overflow
`ifdef ADDER_16BIT_ARB_STATS_EN
  ,output logic [15:0]             stat_acc_count,
  output logic [15:0]              stat_stall_count
`endif
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  logic [0:0]       state;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   win;
  logic             any;
  logic             free;
  logic             xfer;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   full_sum;
  assign rsp_valid = state == FULL;
  assign free      = rst && (state == EMPTY || rsp_ready);
  assign xfer      = free && any;
  // Scan from farthest to nearest offset so the nearest requester after last_grant wins.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[IDW'((int'(last_grant) + k) % NUM_REQ)]) begin
        win = IDW'((int'(last_grant) + k) % NUM_REQ);
        any = 1'b1;
      end
    end
    req_ready = '0;
    if (xfer) req_ready[win] = 1'b1;
  end
  assign a        = req_a[win*WIDTH +: WIDTH];
  assign b        = req_b[win*WIDTH +: WIDTH];
  assign full_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, req_cin[win]};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= EMPTY;
      last_grant   <= IDW'(NUM_REQ - 1);
      rsp_id       <= '0;
      rsp_sum      <= '0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
    end else if (xfer) begin
      state        <= FULL;
      last_grant   <= win;
      rsp_id       <= win;
      rsp_sum      <= full_sum[WIDTH-1:0];
      rsp_cout     <= full_sum[WIDTH];
      rsp_overflow <= (a[WIDTH-1] == b[WIDTH-1]) && (full_sum[WIDTH-1] != a[WIDTH-1]);
    end else if (rsp_ready) begin
      state        <= EMPTY;
    end
  end
`ifdef ADDER_16BIT_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_acc_count   <= '0;
      stat_stall_count <= '0;
    end else begin
      if (xfer && !(&stat_acc_count)) stat_acc_count <= stat_acc_count + 16'd1;
      if (rsp_valid && !rsp_ready && !(&stat_stall_count)) stat_stall_count <= stat_stall_count + 16'd1;
    end
  end
`endif
endmodule
